// File: rtl/traffic_pkg.sv
// Shared lamp encodings, phase enum and fault-bit indices for the traffic
// controller and its passive monitor.
package traffic_pkg;

   localparam int CAR_BIT_RED  = 3;
   localparam int CAR_BIT_YEL  = 2;
   localparam int CAR_BIT_GRN  = 1;
   localparam int CAR_BIT_LEFT = 0;

   localparam logic [3:0] CAR_RED  = 4'b1000;
   localparam logic [3:0] CAR_YEL  = 4'b0100;
   localparam logic [3:0] CAR_GRN  = 4'b0010;
   localparam logic [3:0] CAR_LEFT = 4'b0001;

   localparam logic [1:0] WLK_STOP = 2'b10;
   localparam logic [1:0] WLK_WALK = 2'b01;
   localparam logic [1:0] WLK_OFF  = 2'b00;
   localparam logic [1:0] WLK_BAD  = 2'b11;

   typedef enum logic [1:0] {
      PH_RED  = 2'd0,
      PH_GRN  = 2'd1,
      PH_YEL  = 2'd2,
      PH_LEFT = 2'd3
   } phase_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_TRACK = 1'b1
   } mon_state_t;

   localparam int FLT_CONFLICT = 0;
   localparam int FLT_ENCODING = 1;
   localparam int FLT_SEQUENCE = 2;
   localparam int FLT_TIMING   = 3;

endpackage

// File: rtl/traffic_monitor_phase_decoder.sv
// One-hot car lamp decode to phase, plus legality of the step from the
// previous phase (a hold counts as legal).
module phase_decoder
   import traffic_pkg::*;
(
   input  logic [3:0] car,
   input  phase_t     prev,
   output logic       legal,
   output phase_t     phase,
   output logic       trans_ok
);

   always_comb begin
      legal = 1'b1;
      phase = prev;
      case (car)
         CAR_RED:  phase = PH_RED;
         CAR_GRN:  phase = PH_GRN;
         CAR_YEL:  phase = PH_YEL;
         CAR_LEFT: phase = PH_LEFT;
         default:  legal = 1'b0;
      endcase
   end

   always_comb begin
      trans_ok = 1'b0;
      if (phase == prev) begin
         trans_ok = 1'b1;
      end else begin
         case (prev)
            PH_RED:  trans_ok = (phase == PH_GRN) || (phase == PH_LEFT);
            PH_GRN:  trans_ok = (phase == PH_YEL);
            PH_LEFT: trans_ok = (phase == PH_YEL);
            PH_YEL:  trans_ok = (phase == PH_RED);
            default: trans_ok = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/traffic_monitor.sv
// Passive observer of the traffic controller lamp buses: sticky safety,
// encoding, sequence and timing flags plus a completed-cycle counter.
//
// state    | meaning
// ST_IDLE  | not tracking; waits for a legal RED sample while enabled
// ST_TRACK | following the car phase sequence and dwell times
module traffic_monitor
   import traffic_pkg::*;
#(
   parameter int MIN_YELLOW = 3,
   parameter int MAX_DWELL  = 100,
   parameter int CNT_W      = 16,
   parameter int DWELL_W    = 8
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_enable,
   input  logic             i_clear,
   input  logic [3:0]       i_car_traffic,
   input  logic [1:0]       i_walker_traffic,
   output logic             o_fault,
   output logic [3:0]       o_fault_code,
   output logic             o_fault_pulse,
   output logic [1:0]       o_car_phase,
   output logic [CNT_W-1:0] o_cycle_cnt
);

   localparam logic [DWELL_W-1:0] MIN_Y     = DWELL_W'(MIN_YELLOW);
   localparam logic [DWELL_W-1:0] MAX_D     = DWELL_W'(MAX_DWELL);
   localparam logic [DWELL_W-1:0] DWELL_SAT = '1;
   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

   logic [3:0]         car_q;
   logic [1:0]         wlk_q;
   logic               seen_q;
   mon_state_t         state, state_nxt;
   phase_t             phase_q, dec_phase;
   logic               dec_legal, dec_ok;
   logic [DWELL_W-1:0] dwell_q, dwell_nxt;
   logic [3:0]         flags_q, viol;
   logic               pulse_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               phase_chg, cnt_inc;

   phase_decoder u_dec (
      .car      (car_q),
      .prev     (phase_q),
      .legal    (dec_legal),
      .phase    (dec_phase),
      .trans_ok (dec_ok)
   );

   // seen_q keeps the reset value of car_q from counting as a RED sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         car_q  <= CAR_RED;
         wlk_q  <= WLK_STOP;
         seen_q <= 1'b0;
      end else begin
         car_q  <= i_car_traffic;
         wlk_q  <= i_walker_traffic;
         seen_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!i_enable)
         state_nxt = ST_IDLE;
      else if (state == ST_IDLE && seen_q && car_q == CAR_RED)
         state_nxt = ST_TRACK;
   end

   always_comb begin
      viol      = '0;
      dwell_nxt = '0;
      cnt_inc   = 1'b0;
      phase_chg = dec_legal && (dec_phase != phase_q);
      if (i_enable) begin
         viol[FLT_CONFLICT] = (wlk_q == WLK_WALK || wlk_q == WLK_OFF) && car_q != CAR_RED;
         case (state)
            ST_IDLE: begin
               if (seen_q && car_q == CAR_RED) dwell_nxt = DWELL_ONE;
            end
            ST_TRACK: begin
               viol[FLT_ENCODING] = !dec_legal || wlk_q == WLK_BAD;
               if (phase_chg) begin
                  dwell_nxt          = DWELL_ONE;
                  viol[FLT_SEQUENCE] = !dec_ok;
                  viol[FLT_TIMING]   = phase_q == PH_YEL && dec_phase == PH_RED && dwell_q < MIN_Y;
                  cnt_inc            = phase_q == PH_RED && dec_phase == PH_GRN;
               end else begin
                  dwell_nxt        = (dwell_q == DWELL_SAT) ? dwell_q : dwell_q + 1'b1;
                  viol[FLT_TIMING] = dwell_q == MAX_D;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= PH_RED;
         dwell_q <= '0;
         flags_q <= '0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (dec_legal) phase_q <= dec_phase;
         dwell_q <= dwell_nxt;
         pulse_q <= |viol;
         if (i_clear) begin
            flags_q <= '0;
            cnt_q   <= '0;
         end else begin
            flags_q <= flags_q | viol;
            if (cnt_inc) cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign o_fault       = |flags_q;
   assign o_fault_code  = flags_q;
   assign o_fault_pulse = pulse_q;
   assign o_car_phase   = phase_q;
   assign o_cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: lamp sequences with hand-computed
// flag, phase, pulse and counter expectations.
module tb_traffic_monitor;
   import traffic_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_enable;
   logic        i_clear;
   logic [3:0]  car;
   logic [1:0]  wlk;
   logic        o_fault;
   logic [3:0]  o_fault_code;
   logic        o_fault_pulse;
   logic [1:0]  o_car_phase;
   logic [15:0] o_cycle_cnt;

   int n_chk = 0;
   int n_err = 0;
   int n_pulse = 0;
   int p0;

   traffic_monitor dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_enable         (i_enable),
      .i_clear          (i_clear),
      .i_car_traffic    (car),
      .i_walker_traffic (wlk),
      .o_fault          (o_fault),
      .o_fault_code     (o_fault_code),
      .o_fault_pulse    (o_fault_pulse),
      .o_car_phase      (o_car_phase),
      .o_cycle_cnt      (o_cycle_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (reset_n === 1'b1 && o_fault_pulse === 1'b1) n_pulse++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic hold(input logic [3:0] c, input logic [1:0] w, input int n);
      car = c;
      wlk = w;
      repeat (n) tick();
   endtask

   initial begin
      reset_n  = 1'b0;
      i_enable = 1'b1;
      i_clear  = 1'b0;
      car      = CAR_RED;
      wlk      = WLK_STOP;
      #2;
      chk("rst_fault", o_fault, 0);
      chk("rst_code", o_fault_code, 0);
      chk("rst_pulse", o_fault_pulse, 0);
      chk("rst_phase", o_car_phase, 0);
      chk("rst_cnt", o_cycle_cnt, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // legal cycle
      hold(CAR_RED, WLK_WALK, 10);
      chk("t1_red_phase", o_car_phase, 0);
      hold(CAR_GRN, WLK_STOP, 2);
      chk("t1_grn_phase", o_car_phase, 1);
      hold(CAR_GRN, WLK_STOP, 18);
      hold(CAR_YEL, WLK_STOP, 2);
      chk("t1_yel_phase", o_car_phase, 2);
      hold(CAR_YEL, WLK_STOP, 1);
      hold(CAR_RED, WLK_STOP, 5);
      chk("t1_back_red", o_car_phase, 0);
      chk("t1_cnt", o_cycle_cnt, 1);
      chk("t1_fault", o_fault, 0);
      chk("t1_no_pulses", n_pulse, 0);

      // walker WALK during GREEN for one clock
      hold(CAR_GRN, WLK_STOP, 5);
      car = CAR_GRN; wlk = WLK_WALK;
      tick();
      wlk = WLK_STOP;
      chk("t2_pulse_early", o_fault_pulse, 0);
      tick();
      chk("t2_pulse", o_fault_pulse, 1);
      chk("t2_code", o_fault_code, 4'b0001);
      tick();
      chk("t2_pulse_end", o_fault_pulse, 0);
      chk("t2_cnt", o_cycle_cnt, 2);

      // bad encoding inside GREEN
      i_clear = 1'b1; tick(); i_clear = 1'b0;
      chk("t3_clear_code", o_fault_code, 0);
      chk("t3_clear_cnt", o_cycle_cnt, 0);
      hold(4'b0110, WLK_STOP, 1);
      hold(CAR_GRN, WLK_STOP, 4);
      chk("t3_code", o_fault_code, 4'b0010);
      chk("t3_phase", o_car_phase, 1);

      // GREEN -> RED direct
      i_clear = 1'b1; tick(); i_clear = 1'b0;
      hold(CAR_RED, WLK_STOP, 3);
      chk("t4_seq_code", o_fault_code, 4'b0100);
      chk("t4_seq_phase", o_car_phase, 0);

      // short YELLOW
      i_clear = 1'b1; tick(); i_clear = 1'b0;
      hold(CAR_GRN, WLK_STOP, 3);
      hold(CAR_YEL, WLK_STOP, 2);
      hold(CAR_RED, WLK_STOP, 3);
      chk("t4_short_yel", o_fault_code, 4'b1000);

      // GREEN overstaying MAX_DWELL
      i_clear = 1'b1; tick(); i_clear = 1'b0;
      p0 = n_pulse;
      hold(CAR_GRN, WLK_STOP, 101);
      chk("t4_dwell_100_ok", o_fault_code, 0);
      hold(CAR_GRN, WLK_STOP, 1);
      chk("t4_dwell_101", o_fault_code, 4'b1000);
      hold(CAR_GRN, WLK_STOP, 20);
      chk("t4_one_pulse", n_pulse - p0, 1);
      chk("t4_cnt", o_cycle_cnt, 1);

      // clear colliding with a new CONFLICT
      hold(CAR_YEL, WLK_STOP, 3);
      hold(CAR_RED, WLK_STOP, 3);
      hold(CAR_GRN, WLK_STOP, 3);
      wlk = WLK_WALK;
      tick();
      wlk = WLK_STOP; i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      chk("t5_clear_wins", o_fault_code, 0);
      chk("t5_fault_low", o_fault, 0);
      wlk = WLK_OFF;
      tick();
      wlk = WLK_STOP;
      tick();
      chk("t5_reset_flag", o_fault_code, 4'b0001);
      chk("t5_fault_high", o_fault, 1);

      // async reset mid-YELLOW
      hold(CAR_YEL, WLK_STOP, 2);
      chk("t6_pre_phase", o_car_phase, 2);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_fault", o_fault, 0);
      chk("t6_rst_code", o_fault_code, 0);
      chk("t6_rst_phase", o_car_phase, 0);
      chk("t6_rst_pulse", o_fault_pulse, 0);
      #9;
      reset_n = 1'b1;
      hold(CAR_GRN, WLK_STOP, 5);
      chk("t6_idle_code", o_fault_code, 0);
      chk("t6_idle_cnt", o_cycle_cnt, 0);
      hold(CAR_RED, WLK_STOP, 3);
      hold(CAR_GRN, WLK_STOP, 3);
      chk("t6_track_cnt", o_cycle_cnt, 1);
      chk("t6_track_code", o_fault_code, 0);

      // disabled checking, then CONFLICT while in IDLE
      i_enable = 1'b0;
      hold(CAR_GRN, WLK_WALK, 4);
      chk("t7_disabled", o_fault_code, 0);
      i_enable = 1'b1;
      hold(CAR_GRN, WLK_WALK, 3);
      chk("t7_idle_conflict", o_fault_code, 4'b0001);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
